// File: rtl/ram_array.sv
// Storage core of the delay-line buffer: one write port, two asynchronous raw read taps.
// Word clear on reset; output registering and range masking live in the parent.
module ram_array #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_di,
    input  logic [ADDR_WIDTH-1:0] i_raddr1,
    input  logic [ADDR_WIDTH-1:0] i_raddr2,
    output logic [DATA_WIDTH-1:0] o_rd1,
    output logic [DATA_WIDTH-1:0] o_rd2
);

    logic [DATA_WIDTH-1:0] ram [0:SIZE-1];

    // Reset wins over a same-edge write; i_we is already qualified by the address range.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SIZE; i++) begin
                ram[i] <= '0;
            end
        end else if (i_we) begin
            ram[i_waddr] <= i_di;
        end
    end

    assign o_rd1 = ram[i_raddr1];
    assign o_rd2 = ram[i_raddr2];

endmodule

// File: rtl/dual_port_memory.sv
// Simple dual-port RAM for the effects delay line: port 1 write/read-back, port 2 read tap.
// Both reads are registered and read-first; out-of-range addresses read 0 and never write.
module dual_port_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic [ADDR_WIDTH-1:0] ADDR2,
    output logic [DATA_WIDTH-1:0] DO1,
    output logic [DATA_WIDTH-1:0] DO2
);

    if (SIZE < 1 || SIZE > (1 << ADDR_WIDTH)) begin : g_bad_size
        $error("dual_port_memory: SIZE must be in 1..2**ADDR_WIDTH");
    end

    // SIZE fits in ADDR_WIDTH+1 bits, so the range test needs no wider compare.
    localparam logic [ADDR_WIDTH:0] LP_SIZE = (ADDR_WIDTH + 1)'(SIZE);

    logic                  w_in1;
    logic                  w_in2;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;
    logic [DATA_WIDTH-1:0] r_do1;
    logic [DATA_WIDTH-1:0] r_do2;

    assign w_in1 = ({1'b0, ADDR1} < LP_SIZE);
    assign w_in2 = ({1'b0, ADDR2} < LP_SIZE);

    ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIZE       (SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) RAM (
        .CLK      (CLK),
        .RST      (RST),
        .i_we     (WE & w_in1),
        .i_waddr  (ADDR1),
        .i_di     (DI),
        .i_raddr1 (ADDR1),
        .i_raddr2 (ADDR2),
        .o_rd1    (w_rd1),
        .o_rd2    (w_rd2)
    );

    // Sampling the array before its same-edge update gives read-first behaviour.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_do1 <= '0;
            r_do2 <= '0;
        end else begin
            r_do1 <= w_in1 ? w_rd1 : '0;
            r_do2 <= w_in2 ? w_rd2 : '0;
        end
    end

    assign DO1 = r_do1;
    assign DO2 = r_do2;

endmodule

// File: tb/tb_dual_port_memory.sv
// Bench for dual_port_memory: a full-size instance (SIZE=8) and a short one (SIZE=6)
// share stimulus and are compared against a plain array model every cycle.
module tb_dual_port_memory;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        WE  = 1'b0;
    logic [2:0]  ADDR1 = '0;
    logic [2:0]  ADDR2 = '0;
    logic [31:0] DI  = '0;
    logic [31:0] DO1_a, DO2_a, DO1_b, DO2_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] m8 [8];
    logic [31:0] m6 [6];

    always #5 CLK = ~CLK;

    dual_port_memory #(.DATA_WIDTH(32), .SIZE(8), .ADDR_WIDTH(3)) u_a (
        .CLK(CLK), .RST(RST), .WE(WE), .ADDR1(ADDR1), .DI(DI), .ADDR2(ADDR2),
        .DO1(DO1_a), .DO2(DO2_a)
    );

    dual_port_memory #(.DATA_WIDTH(32), .SIZE(6), .ADDR_WIDTH(3)) u_b (
        .CLK(CLK), .RST(RST), .WE(WE), .ADDR1(ADDR1), .DI(DI), .ADDR2(ADDR2),
        .DO1(DO1_b), .DO2(DO2_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd8(input logic [2:0] a);
        return m8[a];
    endfunction

    function automatic logic [31:0] rd6(input logic [2:0] a);
        return (int'(a) < 6) ? m6[a] : 32'd0;
    endfunction

    // One clock: drive, clock, update the model, then compare all four outputs.
    task automatic cycle(input string tag, input logic rst, input logic we,
                         input logic [2:0] a1, input logic [31:0] di, input logic [2:0] a2);
        logic [31:0] e1a, e2a, e1b, e2b;
        RST = rst; WE = we; ADDR1 = a1; DI = di; ADDR2 = a2;
        @(posedge CLK);
        if (rst) begin
            e1a = 0; e2a = 0; e1b = 0; e2b = 0;
            foreach (m8[i]) m8[i] = 0;
            foreach (m6[i]) m6[i] = 0;
        end else begin
            e1a = rd8(a1); e2a = rd8(a2);
            e1b = rd6(a1); e2b = rd6(a2);
            if (we) m8[a1] = di;
            if (we && int'(a1) < 6) m6[a1] = di;
        end
        #1;
        chk({tag, ".A.DO1"}, DO1_a, e1a);
        chk({tag, ".A.DO2"}, DO2_a, e2a);
        chk({tag, ".B.DO1"}, DO1_b, e1b);
        chk({tag, ".B.DO2"}, DO2_b, e2b);
    endtask

    initial begin
        // Reset, then confirm every address reads zero on both ports.
        cycle("reset", 1'b1, 1'b0, 3'd0, 32'd0, 3'd0);
        chk("reset.lit.DO1", DO1_a, 32'd0);
        for (int i = 0; i < 8; i++) cycle("rd_zero", 1'b0, 1'b0, 3'(i), 32'd0, 3'(7 - i));

        // Single write then read on port 2.
        cycle("wr2", 1'b0, 1'b1, 3'd2, 32'd10, 3'd0);
        cycle("rd2", 1'b0, 1'b0, 3'd0, 32'd0, 3'd2);
        chk("rd2.lit", DO2_a, 32'd10);
        cycle("rd_other", 1'b0, 1'b0, 3'd1, 32'd0, 3'd3);

        // Fill and sweep.
        for (int i = 0; i < 8; i++) cycle("fill", 1'b0, 1'b1, 3'(i), 32'(i), 3'd0);
        for (int i = 0; i < 8; i++) cycle("sweep", 1'b0, 1'b0, 3'd0, 32'd0, 3'(i));
        cycle("sweep_tail", 1'b0, 1'b0, 3'd0, 32'd0, 3'd0);

        // Offset write/read pointers, wrapping through address 0.
        for (int i = 0; i < 8; i++) cycle("offset", 1'b0, 1'b1, 3'(i), 32'(10 * (i + 1)), 3'(i + 1));
        chk("offset.wrap.lit", DO2_a, 32'd10);

        // Collision at address 5 (refill first so mem[5]=5).
        for (int i = 0; i < 8; i++) cycle("refill", 1'b0, 1'b1, 3'(i), 32'(i), 3'd0);
        cycle("coll", 1'b0, 1'b1, 3'd5, 32'd99, 3'd5);
        chk("coll.old.DO1", DO1_a, 32'd5);
        chk("coll.old.DO2", DO2_a, 32'd5);
        cycle("coll_next", 1'b0, 1'b0, 3'd5, 32'd0, 3'd5);
        chk("coll.new.DO2", DO2_a, 32'd99);

        // Out-of-range on the short instance: write to 7 ignored, read returns 0.
        cycle("oor_wr", 1'b0, 1'b1, 3'd7, 32'hDEAD_BEEF, 3'd6);
        cycle("oor_rd", 1'b0, 1'b0, 3'd7, 32'd0, 3'd7);
        chk("oor.lit.B", DO1_b, 32'd0);

        // Reset with a simultaneous write.
        cycle("rst_wr", 1'b1, 1'b1, 3'd3, 32'd77, 3'd3);
        chk("rst_wr.ram3", u_a.RAM.ram[3], 32'd0);
        cycle("rst_rd3", 1'b0, 1'b0, 3'd3, 32'd0, 3'd3);
        chk("rst_rd3.lit", DO1_a, 32'd0);

        // Randomised traffic including occasional resets.
        for (int n = 0; n < 400; n++) begin
            cycle("rand", ($urandom_range(0, 49) == 0), 1'($urandom), 3'($urandom),
                  $urandom, 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
